mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Shares one sram-like memory port between the instruction-fetch master and the data-memory master.
//  Sits between the IF/MEM pipeline stages and the sram-like-to-AXI bridge.
//  Serialises transactions with one outstanding at a time.
//  Generates stallreq_from_if / stallreq_from_mem for the hazard unit.
//  Discards fetch responses that were killed by an exception flush.
// PARAMETERS
//  ADDR_W  32  address width of all ports
//  DATA_W  32  read/write data width of all ports
// PORTS
//  clk               in   1       clock; all state on rising edge
//  rst               in   1       reset, asynchronous, active-high
//  inst_req          in   1       fetch request (read only)
//  inst_addr         in   ADDR_W  fetch address
//  inst_addr_ok      out  1       fetch address accepted
//  inst_data_ok      out  1       fetch data valid
//  inst_rdata        out  DATA_W  fetch data
//  inst_flush        in   1       flush_except; kills in-flight fetch
//  data_req          in   1       load/store request
//  data_wr           in   1       1 = store
//  data_size         in   2       0 = byte, 1 = half, 2 = word
//  data_addr         in   ADDR_W  load/store address
//  data_wdata        in   DATA_W  store data
//  data_addr_ok      out  1       data address accepted
//  data_data_ok      out  1       load data valid / store done
//  data_rdata        out  DATA_W  load data
//  mem_req           out  1       slave request
//  mem_wr            out  1       slave write
//  mem_size          out  2       slave size
//  mem_addr          out  ADDR_W  slave address
//  mem_wdata         out  DATA_W  slave write data
//  mem_addr_ok       in   1       slave address handshake
//  mem_data_ok       in   1       slave response
//  mem_rdata         in   DATA_W  slave read data
//  stallreq_from_if  out  1       inst_req & ~inst_data_ok
//  stallreq_from_mem out  1       data_req & ~data_data_ok
// BEHAVIOUR
//  Reset values:
//   - state = IDLE; owner = NONE; drop = 0.
//   - all mem_* outputs 0; all *_ok outputs 0; rdata outputs 0.
//  FSM states: IDLE -> REQ -> WAIT -> IDLE.
//  IDLE:
//   - On any request pending, grant a winner.
//   - Latch the winner's wr/size/addr/wdata into registers (inst: wr = 0, size = 2).
//   - Set owner and go to REQ.
//   - Slave req is asserted the following cycle, so the arbiter adds 1 cycle of latency.
//  REQ:
//   - mem_req = 1 with the latched fields.
//   - inst_addr_ok / data_addr_ok = mem_addr_ok gated by owner (combinational).
//   - Stay in REQ until mem_addr_ok, then go to WAIT.
//  WAIT:
//   - mem_req = 0.
//   - On mem_data_ok: route it and mem_rdata combinationally to the owner's *_data_ok / *_rdata, then go to IDLE.
//  Non-owner outputs: the non-owner's *_addr_ok and *_data_ok are always 0.
//  Arbitration: fixed data priority. When both requests are high in IDLE, data wins.
//  Flush of a fetch:
//   - If inst_flush is high while owner = INST in REQ or WAIT, set drop.
//   - The transaction still completes on the slave; the request is never withdrawn.
//   - inst_data_ok is suppressed at completion; drop clears in IDLE.
//   - If inst_flush and mem_data_ok arrive in the same cycle, the response is dropped.
//  Flush in IDLE has no effect.
//  Master obligations:
//   - A master holds req and its fields until its addr_ok.
//   - A master that drops req before the grant loses nothing, because sampling happens only in IDLE.
//  Reset mid-transaction: FSM returns to IDLE asynchronously and the pending response is lost. The bridge is reset with it.
//  rdata outputs are 0 whenever their data_ok is 0.
// CONFIGURATION
//  MEM_ARB_RR_EN defined:
//   - Round-robin arbitration on a 1-bit last_grant register (reset = DATA).
//   - On a conflict, the master not granted last wins.
//   - last_grant updates on entry to REQ.
//  MEM_ARB_RR_EN undefined: fixed data priority as above; no last_grant register.
// STRUCTURE
//  mem_arb_pkg:
//   - state encoding (IDLE/REQ/WAIT)
//   - owner encoding (NONE/INST/DATA)
//   - SIZE_BYTE / SIZE_HALF / SIZE_WORD constants
//  No sub-module: the FSM, latch registers and output muxes are one flat module.
// TESTING
//  1. Single fetch:
//     - Stimulus: inst_req = 1, addr = 0xBFC00000; slave addr_ok at +2, data_ok at +4 with rdata = 0x24080001.
//     - Response: inst_data_ok pulses 1 cycle with 0x24080001; stallreq_from_if deasserts that cycle.
//  2. Conflict:
//     - Stimulus: inst_req and a data store (addr = 0x80000010, wdata = 0xDEADBEEF, size = 2) in the same cycle.
//     - Response: the store issues first; the fetch issues on the 2nd REQ.
//     - With MEM_ARB_RR_EN, a second conflict grants INST first.
//  3. Flush in WAIT:
//     - Stimulus: inst_flush pulses while a fetch waits.
//     - Response: mem_data_ok arrives, inst_data_ok stays 0, the FSM returns to IDLE, and the next fetch proceeds normally.
//  4. Slow addr_ok:
//     - Stimulus: mem_addr_ok held low for 5 cycles.
//     - Response: mem_req and mem_addr stay stable all 5 cycles; neither *_addr_ok fires early.
//  5. Reset:
//     - Stimulus: rst asserted in WAIT.
//     - Response: all outputs 0 immediately, before the next clk edge; state = IDLE after release.
//  6. Byte load:
//     - Stimulus: data_size = 0, addr = 0x80000003.
//     - Response: mem_size = 0, mem_wr = 0, mem_addr = 0x80000003; data_rdata = mem_rdata on data_ok.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state/owner encodings and access-size constants shared by the memory request arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic [1:0] {NONE, INST, DATA} owner_t;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one sram-like port between fetch and data masters, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data priority.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              inst_flush,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq_from_if,
  output logic              stallreq_from_mem
);
  state_t state;
  owner_t owner;
  logic   drop;
  logic   grant_data;
`ifdef MEM_ARB_RR_EN
  logic last_data;
  always_comb grant_data = data_req & ~(inst_req & last_data);
`else
  always_comb grant_data = data_req;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= NONE;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_size  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
      last_data <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (inst_req | data_req) begin
            state     <= REQ;
            owner     <= grant_data ? DATA : INST;
            mem_req   <= 1'b1;
            mem_wr    <= grant_data & data_wr;
            mem_size  <= grant_data ? data_size : SIZE_WORD;
            mem_addr  <= grant_data ? data_addr : inst_addr;
            mem_wdata <= grant_data ? data_wdata : '0;
`ifdef MEM_ARB_RR_EN
            last_data <= grant_data;
`endif
          end
        end
        REQ: begin
          if (inst_flush && owner == INST) drop <= 1'b1;
          if (mem_addr_ok) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (inst_flush && owner == INST) drop <= 1'b1;
          if (mem_data_ok) begin
            state <= IDLE;
            owner <= NONE;
          end
        end
        default: begin
          state   <= IDLE;
          owner   <= NONE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end
  // a flush in the completion cycle itself also kills the fetch response
  always_comb begin
    inst_addr_ok      = mem_req & (owner == INST) & mem_addr_ok;
    data_addr_ok      = mem_req & (owner == DATA) & mem_addr_ok;
    inst_data_ok      = (state == WAIT) & (owner == INST) & mem_data_ok & ~drop & ~inst_flush;
    data_data_ok      = (state == WAIT) & (owner == DATA) & mem_data_ok;
    inst_rdata        = inst_data_ok ? mem_rdata : '0;
    data_rdata        = data_data_ok ? mem_rdata : '0;
    stallreq_from_if  = inst_req & ~inst_data_ok;
    stallreq_from_mem = data_req & ~data_data_ok;
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_req_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1;
  logic        inst_req = 0, inst_flush = 0, data_req = 0, data_wr = 0;
  logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, mem_rdata = 0;
  logic [1:0]  data_size = 0;
  logic        mem_addr_ok = 0, mem_data_ok = 0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_wr, stallreq_from_if, stallreq_from_mem;
  logic [1:0]  mem_size;
  int n_checks = 0, n_fail = 0;
  mem_req_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_flush(inst_flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .stallreq_from_if(stallreq_from_if), .stallreq_from_mem(stallreq_from_mem)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic serve(input int aw, input int dw, input logic [31:0] rd);
    repeat (aw) step();
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0;
    repeat (dw) step();
    mem_data_ok = 1;
    mem_rdata = rd;
    @(negedge clk);
  endtask
  // transaction-level reference: one granted transfer at a time, issued then answered
  bit m_busy = 0, m_sent = 0, m_data = 0, m_kill = 0, m_last_data = 1, chk_en = 0;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  bit e_req, e_iaok, e_daok, e_idok, e_ddok;
  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_sent = 0; m_kill = 0; m_last_data = 1;
    end else if (chk_en) begin
      e_req  = m_busy && !m_sent;
      e_iaok = e_req && !m_data && mem_addr_ok;
      e_daok = e_req && m_data && mem_addr_ok;
      e_idok = m_busy && m_sent && !m_data && mem_data_ok && !m_kill && !inst_flush;
      e_ddok = m_busy && m_sent && m_data && mem_data_ok;
      check("mem_req", mem_req, e_req);
      check("inst_addr_ok", inst_addr_ok, e_iaok);
      check("data_addr_ok", data_addr_ok, e_daok);
      check("inst_data_ok", inst_data_ok, e_idok);
      check("data_data_ok", data_data_ok, e_ddok);
      check("inst_rdata", inst_rdata, e_idok ? mem_rdata : 32'h0);
      check("data_rdata", data_rdata, e_ddok ? mem_rdata : 32'h0);
      check("stall_if", stallreq_from_if, inst_req && !e_idok);
      check("stall_mem", stallreq_from_mem, data_req && !e_ddok);
      if (e_req) begin
        check("mem_addr", mem_addr, m_addr);
        check("mem_wr", mem_wr, m_wr);
        check("mem_size", mem_size, m_size);
        if (m_data) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_busy) begin
        if (!m_data && inst_flush) m_kill = 1;
        if (!m_sent) m_sent = mem_addr_ok;
        else if (mem_data_ok) m_busy = 0;
      end else if (inst_req || data_req) begin
        m_data = data_req && !(inst_req && RR && m_last_data);
        m_last_data = m_data;
        m_addr  = m_data ? data_addr : inst_addr;
        m_wr    = m_data && data_wr;
        m_size  = m_data ? data_size : 2'd2;
        m_wdata = data_wdata;
        m_busy = 1; m_sent = 0; m_kill = 0;
      end
    end
  end
  logic [31:0] first_a, second_a, held_a;
  initial begin
    step();
    step();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    rst = 0;
    chk_en = 1;
    step();
    // single fetch
    inst_req = 1; inst_addr = 32'hBFC00000;
    step();
    check("t1_req", mem_req, 1);
    check("t1_addr", mem_addr, 32'hBFC00000);
    serve(1, 1, 32'h24080001);
    check("t1_dok", inst_data_ok, 1);
    check("t1_rdata", inst_rdata, 32'h24080001);
    check("t1_stall", stallreq_from_if, 0);
    step();
    mem_data_ok = 0; inst_req = 0;
    step();
    // conflict: store and fetch together, then a second store meets the waiting fetch
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
    inst_req = 1; inst_addr = 32'hBFC00004;
    step();
    check("t2_first_wr", mem_wr, 1);
    check("t2_first_addr", mem_addr, 32'h80000010);
    check("t2_first_wdata", mem_wdata, 32'hDEADBEEF);
    serve(0, 1, 0);
    check("t2_store_done", data_data_ok, 1);
    check("t2_no_inst", inst_data_ok, 0);
    step();
    mem_data_ok = 0; data_addr = 32'h80000020; data_wdata = 32'h01020304;
    step();
    first_a  = RR ? 32'hBFC00004 : 32'h80000020;
    second_a = RR ? 32'h80000020 : 32'hBFC00004;
    check("t2_second_grant", mem_addr, first_a);
    serve(0, 0, 32'h11111111);
    step();
    mem_data_ok = 0;
    if (RR) inst_req = 0; else data_req = 0;
    step();
    check("t2_third_grant", mem_addr, second_a);
    serve(0, 0, 32'h22222222);
    step();
    mem_data_ok = 0; inst_req = 0; data_req = 0; data_wr = 0;
    step();
    // flush while a fetch waits
    inst_req = 1; inst_addr = 32'hBFC00008;
    step();
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; inst_flush = 1;
    step();
    inst_flush = 0; inst_req = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    check("t3_dropped", inst_data_ok, 0);
    check("t3_rdata", inst_rdata, 0);
    step();
    mem_data_ok = 0;
    step();
    check("t3_idle", mem_req, 0);
    inst_req = 1; inst_addr = 32'hBFC0000C;
    step();
    check("t3_next_addr", mem_addr, 32'hBFC0000C);
    serve(0, 0, 32'h12345678);
    check("t3_next_dok", inst_data_ok, 1);
    check("t3_next_rdata", inst_rdata, 32'h12345678);
    step();
    mem_data_ok = 0; inst_req = 0;
    step();
    // slow address handshake
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000040;
    step();
    held_a = mem_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_req_held", mem_req, 1);
      check("t4_addr_held", mem_addr, held_a);
      check("t4_no_aok", {inst_addr_ok, data_addr_ok}, 0);
      step();
    end
    serve(0, 0, 32'h55AA55AA);
    check("t4_dok", data_data_ok, 1);
    step();
    mem_data_ok = 0; data_req = 0;
    step();
    // asynchronous reset while waiting
    inst_req = 1; inst_addr = 32'hBFC00010;
    step();
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h77777777;
    #2 rst = 1;
    #1;
    check("t5_req", mem_req, 0);
    check("t5_addr", mem_addr, 0);
    check("t5_oks", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    check("t5_rdata", inst_rdata, 0);
    mem_data_ok = 0; inst_req = 0;
    step();
    step();
    rst = 0;
    step();
    check("t5_idle", mem_req, 0);
    inst_req = 1; inst_addr = 32'hBFC00014;
    step();
    check("t5_new_addr", mem_addr, 32'hBFC00014);
    serve(0, 0, 32'h0BADF00D);
    check("t5_new_dok", inst_data_ok, 1);
    step();
    mem_data_ok = 0; inst_req = 0;
    step();
    // byte load
    data_req = 1; data_wr = 0; data_size = 0; data_addr = 32'h80000003;
    step();
    check("t6_size", mem_size, 0);
    check("t6_wr", mem_wr, 0);
    check("t6_addr", mem_addr, 32'h80000003);
    serve(1, 2, 32'hCAFEF00D);
    check("t6_dok", data_data_ok, 1);
    check("t6_rdata", data_rdata, 32'hCAFEF00D);
    step();
    mem_data_ok = 0; data_req = 0;
    step();
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      mem_addr_ok = ($urandom % 3) == 0;
      mem_data_ok = ($urandom % 3) == 0;
      mem_rdata   = $urandom;
      inst_flush  = ($urandom % 8) == 0;
      if (($urandom % 4) == 0) begin
        inst_req  = ~inst_req;
        inst_addr = $urandom & 32'hFFFFFFFC;
      end
      if (($urandom % 4) == 0) begin
        data_req   = ~data_req;
        data_wr    = $urandom % 2;
        data_size  = 2'($urandom % 3);
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      step();
    end
    inst_req = 0; data_req = 0; inst_flush = 0; mem_addr_ok = 0; mem_data_ok = 0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
